// File: rtl/aes_shift_mix_addkey.sv
// AES-256 round stage: ShiftRows -> MixColumns (bypassed on round NR) -> AddRoundKey,
// registered behind a two-entry output/skid buffer. Optional macro AES_SMA_STALL_CNT_EN adds stall_cnt.
module aes_shift_mix_addkey #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] sub_data,
    input  logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last
`ifdef AES_SMA_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        mix_column = {b3, b2, b1, b0};
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        shift_rows = res;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            res[32*c +: 32] = mix_column(s[32*c +: 32]);
        end
        mix_columns = res;
    endfunction

    logic [127:0] out_data_q, out_data_d;
    logic         out_last_q, out_last_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] skid_data_q, skid_data_d;
    logic         skid_last_q, skid_last_d;
    logic         skid_valid_q, skid_valid_d;
    logic [3:0]   round_q, round_d;

    logic         accept;
    logic         xfer;
    logic         is_last;
    logic [127:0] shifted;
    logic [127:0] result;

    assign accept  = in_valid && !skid_valid_q;
    assign xfer    = out_valid_q && out_ready;
    assign is_last = (round_q == LAST_ROUND);
    assign shifted = shift_rows(sub_data);
    assign result  = (is_last ? shifted : mix_columns(shifted)) ^ round_key;

    always_comb begin
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_valid_d = skid_valid_q;
        round_d      = round_q;

        if (accept) begin
            round_d = is_last ? 4'd1 : round_q + 4'd1;
        end

        if (!out_valid_q || xfer) begin
            // Output register is free this cycle: refill from skid first, else from the new beat.
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_data_d  = result;
                out_last_d  = is_last;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_data_d  = result;
            skid_last_d  = is_last;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            round_q      <= 4'd1;
        end else begin
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            round_q      <= round_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
        skid_last_q <= skid_last_d;
    end

`ifdef AES_SMA_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && stall_q != 16'hffff) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign in_ready  = !skid_valid_q;
    assign round_idx = round_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_aes_shift_mix_addkey.sv
// Bench for aes_shift_mix_addkey: known-answer table, backpressure/reset sequences,
// and randomized traffic checked against an array-based AES round model.
module tb_aes_shift_mix_addkey;

    localparam int NR = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] sub_data;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
`ifdef AES_SMA_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    aes_shift_mix_addkey #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub_data  (sub_data),
        .round_key (round_key),
        .round_idx (round_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef AES_SMA_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    typedef struct {
        logic [127:0] sub;
        logic [127:0] key;
        int           rnd;
        logic [127:0] exp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_round;
    int   n_acc;
    exp_t q[$];
    vec_t tbl[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // GF(2^8) multiply by long multiplication then reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input int a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (a[i]) p = p ^ (16'(b) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] kk, input int rnd);
        logic [7:0] st[4][4];
        logic [7:0] sh[4][4];
        logic [7:0] mx[4][4];
        logic [127:0] o;
        int m[4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = s[8*(4*c+r) +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sh[r][c] = st[r][(c+r)%4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (rnd == NR) mx[r][c] = sh[r][c];
                else begin
                    mx[r][c] = 8'h00;
                    for (int j = 0; j < 4; j++) mx[r][c] = mx[r][c] ^ gmul(m[r][j], sh[j][c]);
                end
            end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[8*(4*c+r) +: 8] = mx[r][c] ^ kk[8*(4*c+r) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Check the cycle against the model, apply what the coming edge will do, advance one cycle.
    task automatic step();
        logic acc, xfr;
        exp_t e;
        acc = in_valid && in_ready;
        xfr = out_valid && out_ready;
        check("out_valid", 128'(out_valid), 128'(q.size() > 0));
        check("in_ready", 128'(in_ready), 128'(q.size() < 2));
        check("round_idx", 128'(round_idx), 128'(model_round));
        if (xfr) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
                e = q.pop_front();
                check("out_data", out_data, e.data);
                check("out_last", 128'(out_last), 128'(e.last));
            end
        end
        if (acc) begin
            e.data = ref_round(sub_data, round_key, model_round);
            e.last = (model_round == NR);
            q.push_back(e);
            model_round = (model_round == NR) ? 1 : model_round + 1;
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        model_round = 1;
        n_acc = 0;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_round_idx", 128'(round_idx), 128'(1));
    endtask

    initial begin
        logic [127:0] held;
        int cyc;

        tbl[0] = '{{4{32'h455313db}}, 128'h0, 1, {4{32'hbca14d8e}}};
        tbl[1] = '{{4{32'h455313db}}, {128{1'b1}}, 1, {4{32'h435eb271}}};
        tbl[2] = '{128'h0f0e0d0c0b0a09080706050403020100, 128'h0, 14,
                   128'h0b06010c07020d08030e09040f0a0500};
        tbl[3] = '{128'h0, 128'h00112233445566778899aabbccddeeff, 1,
                   128'h00112233445566778899aabbccddeeff};
        tbl[4] = '{{4{32'h455313db}}, 128'h0, 14, {4{32'h455313db}}};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sub_data = '0;
        round_key = '0;
        model_round = 1;
        n_acc = 0;
        @(negedge clk);

        // Known-answer vectors, preceded by dummy beats to reach the vector's round.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            out_ready = 1'b1;
            in_valid = 1'b1;
            for (int d = 1; d < tbl[t].rnd; d++) begin
                sub_data = rand128();
                round_key = rand128();
                step();
            end
            sub_data = tbl[t].sub;
            round_key = tbl[t].key;
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", t), 128'(out_valid), 128'(1));
            check($sformatf("vec%0d_data", t), out_data, tbl[t].exp);
            check($sformatf("vec%0d_last", t), 128'(out_last), 128'(tbl[t].rnd == NR));
            check($sformatf("vec%0d_round_idx", t), 128'(round_idx),
                  128'((tbl[t].rnd == NR) ? 1 : tbl[t].rnd + 1));
            step();
        end

        // Backpressure: only two beats fit, output held stable, then full-rate drain.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sub_data = rand128();
            round_key = rand128();
            if (n_acc == 1) held = out_data;
            if (n_acc == 2) check("bp_data_stable", out_data, held);
            step();
        end
        check("bp_accept_count", 128'(n_acc), 128'(2));
        check("bp_in_ready_low", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        step();
        cyc = n_acc;
        for (int i = 0; i < 5; i++) begin
            sub_data = rand128();
            round_key = rand128();
            step();
        end
        check("bp_throughput", 128'(n_acc - cyc), 128'(5));
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("bp_drained", 128'(q.size()), 128'(0));

        // Reset with the skid entry full after five accepts.
        do_reset();
        in_valid = 1'b1;
        cyc = 0;
        while (n_acc < 4 && cyc < 20) begin
            sub_data = rand128();
            round_key = rand128();
            step();
            cyc++;
        end
        out_ready = 1'b0;
        while (n_acc < 5 && cyc < 20) begin
            sub_data = rand128();
            round_key = rand128();
            step();
            cyc++;
        end
        check("mid_accepts", 128'(n_acc), 128'(5));
        check("mid_skid_full", 128'(in_ready), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        model_round = 1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_in_ready", 128'(in_ready), 128'(1));
        check("mid_rst_round_idx", 128'(round_idx), 128'(1));
        out_ready = 1'b1;
        sub_data = tbl[0].sub;
        round_key = tbl[0].key;
        step();
        in_valid = 1'b0;
        check("mid_restart_data", out_data, tbl[0].exp);
        check("mid_restart_last", 128'(out_last), 128'(0));
        step();

`ifdef AES_SMA_STALL_CNT_EN
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        sub_data = rand128();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("stall_cnt_10", 128'(stall_cnt), 128'(10));
        do_reset();
        check("stall_cnt_rst", 128'(stall_cnt), 128'(0));
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sub_data = rand128();
            round_key = rand128();
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rand_drained", 128'(q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
